dot_operand_streamer: RTL and testbench

Operand-side driver for the 4-lane int8 dot-product datapath.
- Accepts a command of base addresses and length, then reads packed int8 A/B words from two synchronous SRAM ports.
- Streams one 4-lane beat per cycle into the MAC array, pulsing an accumulator clear before the first beat.
- After the last beat plus a fixed drain, captures the accumulated 32-bit result and returns it over a valid/ready response channel.

---
 rtl/dot_operand_streamer_pkg.sv | 21 ++
 rtl/dot_operand_streamer_if.sv | 49 ++++
 rtl/dot_operand_streamer_addr_gen.sv | 30 +++
 rtl/dot_operand_streamer.sv | 137 +++++++++++++
 tb/tb_dot_operand_streamer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_operand_streamer_pkg.sv
// Shared definitions for the int8 dot-product operand path: FSM states, lane
// geometry and a lane unpack helper also used by the MAC array wrapper.
package dot_operand_streamer_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  function automatic logic signed [LANE_W-1:0] lane(input logic [WORD_W-1:0] w, input int i);
    return $signed(w[i*LANE_W +: LANE_W]);
  endfunction

endpackage

// File: rtl/dot_operand_streamer_if.sv
// Bundles the command, SRAM, operand-stream and response channels of the
// operand streamer; master is the streamer side, slave the surrounding system.
interface dot_operand_streamer_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int RES_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_a_addr;
  logic [ADDR_W-1:0] cmd_b_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              mem_a_en;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [31:0]       mem_a_rdata;
  logic              mem_b_en;
  logic [ADDR_W-1:0] mem_b_addr;
  logic [31:0]       mem_b_rdata;

  logic              acc_clr;
  logic              op_valid;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              op_last;

  logic [RES_W-1:0]  res_in;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_len,
    input  mem_a_rdata, mem_b_rdata, res_in, res_ready,
    output cmd_ready, mem_a_en, mem_a_addr, mem_b_en, mem_b_addr,
    output acc_clr, op_valid, op_a, op_b, op_last,
    output res_valid, res_data, busy
  );

  modport slave (
    output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_len,
    output mem_a_rdata, mem_b_rdata, res_in, res_ready,
    input  cmd_ready, mem_a_en, mem_a_addr, mem_b_en, mem_b_addr,
    input  acc_clr, op_valid, op_a, op_b, op_last,
    input  res_valid, res_data, busy
  );

endinterface

// File: rtl/dot_operand_streamer_addr_gen.sv
// Loadable base+offset SRAM word-address counter; the sum wraps modulo 2^ADDR_W.
module streamer_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              incr,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] offset_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q   <= '0;
      offset_q <= '0;
    end else if (load) begin
      base_q   <= base;
      offset_q <= '0;
    end else if (incr) begin
      offset_q <= offset_q + ADDR_W'(1);
    end
  end

  assign addr = base_q + offset_q;

endmodule

// File: rtl/dot_operand_streamer.sv
// Operand-side sequencer for the 4-lane int8 dot-product datapath: fetches A/B
// words, streams beats into the MAC array and returns the drained sum.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a command, cmd_ready high
// S_CLEAR  | one-cycle accumulator clear, first SRAM read issued if len>0
// S_STREAM | one operand beat per cycle, next word prefetched
// S_DRAIN  | waiting for the MAC pipeline to settle, capture on last cycle
// S_RESP   | result held on res_data until res_ready
module dot_operand_streamer
  import dot_operand_streamer_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 2,
  parameter int RES_W     = 32
) (
  input logic clk,
  input logic rst,
  dot_operand_streamer_if.master bus
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] beats_left;
  logic [DW-1:0]    drain_cnt;
  logic [RES_W-1:0] res_q;

  logic accept, mem_en, load_drain, capture;
  logic cmd_ready, acc_clr, op_valid, op_last, res_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    acc_clr    = 1'b0;
    op_valid   = 1'b0;
    op_last    = 1'b0;
    mem_en     = 1'b0;
    res_valid  = 1'b0;
    load_drain = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        if (beats_left != '0) begin
          mem_en    = 1'b1;
          state_nxt = S_STREAM;
        end else begin
          load_drain = 1'b1;
          state_nxt  = S_DRAIN;
        end
      end
      S_STREAM: begin
        op_valid = 1'b1;
        if (beats_left == LEN_W'(1)) begin
          op_last    = 1'b1;
          load_drain = 1'b1;
          state_nxt  = S_DRAIN;
        end else begin
          mem_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && bus.cmd_valid;

  // beats_left doubles as the latched command length until streaming starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_left <= '0;
      drain_cnt  <= '0;
      res_q      <= '0;
    end else begin
      if (accept)        beats_left <= bus.cmd_len;
      else if (op_valid) beats_left <= beats_left - LEN_W'(1);

      if (load_drain)                                drain_cnt <= DW'(DRAIN_CYC - 1);
      else if (state == S_DRAIN && drain_cnt != '0)  drain_cnt <= drain_cnt - DW'(1);

      if (capture) res_q <= bus.res_in;
    end
  end

  streamer_addr_gen #(.ADDR_W(ADDR_W)) u_addr_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .base (bus.cmd_a_addr),
    .incr (mem_en),
    .addr (bus.mem_a_addr)
  );

  streamer_addr_gen #(.ADDR_W(ADDR_W)) u_addr_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .base (bus.cmd_b_addr),
    .incr (mem_en),
    .addr (bus.mem_b_addr)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.mem_a_en  = mem_en;
  assign bus.mem_b_en  = mem_en;
  assign bus.acc_clr   = acc_clr;
  assign bus.op_valid  = op_valid;
  assign bus.op_last   = op_last;
  assign bus.op_a      = op_valid ? bus.mem_a_rdata : '0;
  assign bus.op_b      = op_valid ? bus.mem_b_rdata : '0;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dot_operand_streamer.sv
// Directed bench for dot_operand_streamer with behavioural SRAMs and a MAC
// accumulator model driving res_in.
module tb_dot_operand_streamer;
  import dot_operand_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_operand_streamer_if #(.ADDR_W(10), .LEN_W(8), .RES_W(32)) bus ();

  dot_operand_streamer #(.ADDR_W(10), .LEN_W(8), .DRAIN_CYC(2), .RES_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic signed [31:0] acc;

  always_ff @(posedge clk) begin
    if (bus.mem_a_en) bus.mem_a_rdata <= mem_a[bus.mem_a_addr];
    if (bus.mem_b_en) bus.mem_b_rdata <= mem_b[bus.mem_b_addr];
  end

  function automatic logic signed [31:0] beat_sum(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] s;
    s = 0;
    for (int i = 0; i < LANES; i++) s = s + lane(a, i) * lane(b, i);
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              acc <= 0;
    else if (bus.acc_clr)  acc <= 0;
    else if (bus.op_valid) acc <= acc + beat_sum(bus.op_a, bus.op_b);
  end

  assign bus.res_in = acc;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept edge is E0; on return the bench is sampling cycle 1
  task automatic send_cmd(input logic [9:0] a, input logic [9:0] b, input logic [7:0] len);
    bus.cmd_a_addr = a;
    bus.cmd_b_addr = b;
    bus.cmd_len    = len;
    bus.cmd_valid  = 1'b1;
    step();
    bus.cmd_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int res_seen;
    bus.cmd_valid  = 1'b0;
    bus.cmd_a_addr = '0;
    bus.cmd_b_addr = '0;
    bus.cmd_len    = '0;
    bus.res_ready  = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[5] = 32'h04030201;
    mem_b[9] = 32'h01010101;
    for (int i = 0; i < 4; i++) begin
      mem_a[100 + i] = 32'h80808080;
      mem_b[200 + i] = 32'h7F7F7F7F;
      mem_b[300 + i] = 32'h02020202;
    end
    mem_a[1022] = 32'h01010101;
    mem_a[1023] = 32'h01010101;
    mem_a[0]    = 32'h01010101;
    mem_a[1]    = 32'h01010101;
    for (int i = 0; i < 8; i++) begin
      mem_a[10 + i] = 32'h01010101;
      mem_b[20 + i] = 32'h01010101;
    end

    // reset state
    #1;
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_res_valid", bus.res_valid, 1'b0);
    chk1("rst_op_valid", bus.op_valid, 1'b0);
    chk1("rst_acc_clr", bus.acc_clr, 1'b0);
    chk1("rst_mem_a_en", bus.mem_a_en, 1'b0);
    chk32("rst_res_data", bus.res_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // len=1
    send_cmd(10'd5, 10'd9, 8'd1);
    chk1("l1_c1_acc_clr", bus.acc_clr, 1'b1);
    chk1("l1_c1_op_valid", bus.op_valid, 1'b0);
    chk1("l1_c1_mem_a_en", bus.mem_a_en, 1'b1);
    chk10("l1_c1_mem_a_addr", bus.mem_a_addr, 10'd5);
    chk10("l1_c1_mem_b_addr", bus.mem_b_addr, 10'd9);
    chk1("l1_c1_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("l1_c1_busy", bus.busy, 1'b1);
    step();
    chk1("l1_c2_op_valid", bus.op_valid, 1'b1);
    chk1("l1_c2_op_last", bus.op_last, 1'b1);
    chk1("l1_c2_acc_clr", bus.acc_clr, 1'b0);
    chk1("l1_c2_mem_a_en", bus.mem_a_en, 1'b0);
    chk32("l1_c2_op_a", bus.op_a, 32'h04030201);
    chk32("l1_c2_op_b", bus.op_b, 32'h01010101);
    step();
    chk1("l1_c3_op_valid", bus.op_valid, 1'b0);
    chk32("l1_c3_op_a", bus.op_a, 32'h0);
    chk1("l1_c3_res_valid", bus.res_valid, 1'b0);
    step();
    chk1("l1_c4_res_valid", bus.res_valid, 1'b0);
    step();
    chk1("l1_c5_res_valid", bus.res_valid, 1'b1);
    chk32("l1_c5_res_data", bus.res_data, 32'd10);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk1("l1_c6_res_valid", bus.res_valid, 1'b0);
    chk1("l1_c6_cmd_ready", bus.cmd_ready, 1'b1);

    // len=4, extreme lanes
    send_cmd(10'd100, 10'd200, 8'd4);
    chk1("l4_c1_acc_clr", bus.acc_clr, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("l4_beat_valid", bus.op_valid, 1'b1);
      chk1("l4_beat_last", bus.op_last, (k == 3));
      chk1("l4_beat_no_clr", bus.acc_clr, 1'b0);
      chk32("l4_beat_op_a", bus.op_a, 32'h80808080);
    end
    step();
    chk1("l4_c6_op_valid", bus.op_valid, 1'b0);
    chk1("l4_c6_res_valid", bus.res_valid, 1'b0);
    step();
    chk1("l4_c7_res_valid", bus.res_valid, 1'b0);
    step();
    chk1("l4_c8_res_valid", bus.res_valid, 1'b1);
    chk32("l4_c8_res_data", bus.res_data, 32'hFFFC0800);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // address wrap 1022,1023,0,1
    send_cmd(10'd1022, 10'd300, 8'd4);
    chk10("wr_c1_a_addr", bus.mem_a_addr, 10'd1022);
    step();
    chk10("wr_c2_a_addr", bus.mem_a_addr, 10'd1023);
    step();
    chk10("wr_c3_a_addr", bus.mem_a_addr, 10'd0);
    chk1("wr_c3_mem_a_en", bus.mem_a_en, 1'b1);
    step();
    chk10("wr_c4_a_addr", bus.mem_a_addr, 10'd1);
    chk10("wr_c4_b_addr", bus.mem_b_addr, 10'd303);
    step();
    chk1("wr_c5_mem_a_en", bus.mem_a_en, 1'b0);
    chk1("wr_c5_op_last", bus.op_last, 1'b1);
    step();
    step();
    step();
    chk1("wr_c8_res_valid", bus.res_valid, 1'b1);
    chk32("wr_c8_res_data", bus.res_data, 32'd32);

    // back-to-back with a stalled response
    bus.cmd_a_addr = 10'd5;
    bus.cmd_b_addr = 10'd9;
    bus.cmd_len    = 8'd1;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bb_hold_res_valid", bus.res_valid, 1'b1);
      chk32("bb_hold_res_data", bus.res_data, 32'd32);
      chk1("bb_hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk1("bb_idle_res_valid", bus.res_valid, 1'b0);
    chk1("bb_idle_cmd_ready", bus.cmd_ready, 1'b1);
    step();
    bus.cmd_valid = 1'b0;
    chk1("bb_c1_acc_clr", bus.acc_clr, 1'b1);
    chk10("bb_c1_a_addr", bus.mem_a_addr, 10'd5);
    step();
    step();
    step();
    step();
    chk1("bb_c5_res_valid", bus.res_valid, 1'b1);
    chk32("bb_c5_res_data", bus.res_data, 32'd10);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // len=0
    send_cmd(10'd0, 10'd0, 8'd0);
    chk1("l0_c1_acc_clr", bus.acc_clr, 1'b1);
    chk1("l0_c1_mem_a_en", bus.mem_a_en, 1'b0);
    step();
    chk1("l0_c2_op_valid", bus.op_valid, 1'b0);
    chk1("l0_c2_res_valid", bus.res_valid, 1'b0);
    step();
    chk1("l0_c3_op_valid", bus.op_valid, 1'b0);
    chk1("l0_c3_res_valid", bus.res_valid, 1'b0);
    step();
    chk1("l0_c4_res_valid", bus.res_valid, 1'b1);
    chk32("l0_c4_res_data", bus.res_data, 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // reset mid-stream at beat 3 of 8
    send_cmd(10'd10, 10'd20, 8'd8);
    step();
    step();
    step();
    step();
    chk1("rs_beat3_op_valid", bus.op_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rs_op_valid", bus.op_valid, 1'b0);
    chk32("rs_op_a", bus.op_a, 32'h0);
    chk1("rs_busy", bus.busy, 1'b0);
    chk1("rs_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rs_mem_a_en", bus.mem_a_en, 1'b0);
    chk10("rs_mem_a_addr", bus.mem_a_addr, 10'd0);
    chk1("rs_acc_clr", bus.acc_clr, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    res_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.res_valid) res_seen++;
    end
    chk1("rs_after_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rs_after_busy", bus.busy, 1'b0);
    chk1("rs_no_res_valid", (res_seen != 0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
